// File: rtl/icache_2way_param.sv
// Two-way set-associative instruction cache with per-set LRU replacement, whole-block refill and flush.
// Hits return the word combinationally; a miss stalls fetch until the victim way is refilled.
module icache_2way_param #(
  parameter int ADDR_WIDTH      = 10,
  parameter int SETS            = 4,
  parameter int WORDS_PER_BLOCK = 4,
  localparam int OB = $clog2(WORDS_PER_BLOCK),
  localparam int IB = $clog2(SETS),
  localparam int TB = ADDR_WIDTH - 2 - OB - IB
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   pc,
  input  logic                          flush,
  output logic [31:0]                   instruction,
  output logic                          busywait,
  output logic                          mem_read,
  output logic [TB+IB-1:0]              mem_address,
  input  logic [32*WORDS_PER_BLOCK-1:0] mem_readdata,
  input  logic                          mem_busywait
);

  typedef enum logic [0:0] {IDLE = 1'b0, MEM_READ = 1'b1} state_t;

  state_t                         state_r;
  state_t                         state_next_s;
  logic [1:0]                     valid_r [SETS];
  logic [SETS-1:0]                lru_r;
  logic [TB-1:0]                  tag_r   [SETS][2];
  logic [32*WORDS_PER_BLOCK-1:0]  data_r  [SETS][2];
  logic [TB+IB-1:0]               miss_addr_r;
  logic                           victim_r;

  logic [OB-1:0]                  offset_s;
  logic [IB-1:0]                  index_s;
  logic [TB-1:0]                  tag_s;
  logic [IB-1:0]                  miss_index_s;
  logic [TB-1:0]                  miss_tag_s;
  logic                           hit0_s;
  logic                           hit1_s;
  logic                           hit_s;
  logic                           victim_s;
  logic [32*WORDS_PER_BLOCK-1:0]  hit_block_s;
  logic [31:0]                    hit_word_s;
  logic [31:0]                    instr_s;
  logic                           busy_s;
  logic                           miss_s;
  logic                           fill_s;
  logic                           lru_upd_s;
  logic                           unused_s;

  assign offset_s     = pc[OB+1:2];
  assign index_s      = pc[OB+IB+1:OB+2];
  assign tag_s        = pc[ADDR_WIDTH-1:OB+IB+2];
  assign miss_index_s = miss_addr_r[IB-1:0];
  assign miss_tag_s   = miss_addr_r[TB+IB-1:IB];
  assign unused_s     = ^{pc[31:ADDR_WIDTH], pc[1:0]};

  assign hit0_s      = valid_r[index_s][0] && (tag_r[index_s][0] == tag_s);
  assign hit1_s      = valid_r[index_s][1] && (tag_r[index_s][1] == tag_s);
  assign hit_s       = hit0_s || hit1_s;
  assign hit_block_s = data_r[index_s][hit1_s];
  assign hit_word_s  = hit_block_s[32*offset_s +: 32];

  // Fill invalid ways first, in way order, before evicting by LRU.
  assign victim_s = !valid_r[index_s][0] ? 1'b0 :
                    (!valid_r[index_s][1] ? 1'b1 : lru_r[index_s]);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state and control decode
  always_comb begin
    state_next_s = state_r;
    instr_s      = 32'h0000_0000;
    busy_s       = 1'b0;
    miss_s       = 1'b0;
    fill_s       = 1'b0;
    lru_upd_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          instr_s   = hit_word_s;
          lru_upd_s = 1'b1;
        end else begin
          busy_s       = 1'b1;
          miss_s       = 1'b1;
          state_next_s = MEM_READ;
        end
      end
      MEM_READ: begin
        busy_s = 1'b1;
        if (!mem_busywait) begin
          fill_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = MEM_READ;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Reset only holds state for the instant it is asserted; the fetch-side outputs must read zero meanwhile.
  assign instruction = reset ? 32'h0000_0000 : instr_s;
  assign busywait    = busy_s & ~reset;
  assign mem_read    = (state_r == MEM_READ);
  assign mem_address = (state_r == MEM_READ) ? miss_addr_r : {(TB+IB){1'b0}};

  // Miss register: block address and victim way of the outstanding refill
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_addr_r <= {(TB+IB){1'b0}};
      victim_r    <= 1'b0;
    end else if (miss_s) begin
      miss_addr_r <= {tag_s, index_s};
      victim_r    <= victim_s;
    end
  end

  // Valid and LRU bits; flush is applied last so it overrides a coincident refill
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) valid_r[s] <= 2'b00;
      lru_r <= {SETS{1'b0}};
    end else begin
      if (fill_s) begin
        valid_r[miss_index_s][victim_r] <= 1'b1;
        lru_r[miss_index_s]             <= ~victim_r;
      end
      if (lru_upd_s) lru_r[index_s] <= ~hit1_s;
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_r[s] <= 2'b00;
        lru_r <= {SETS{1'b0}};
      end
    end
  end

  // Tag and data arrays, qualified by the valid bits
  always_ff @(posedge clock) begin
    if (fill_s) begin
      tag_r[miss_index_s][victim_r]  <= miss_tag_s;
      data_r[miss_index_s][victim_r] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_icache_2way_param.sv
// Directed bench for icache_2way_param: miss/refill timing, hits, LRU eviction, flush and async reset.
module tb_icache_2way_param;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [31:0]  pc;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [1:0]   busy_cnt_r = 2'd0;
  int           pass_cnt = 0;
  int           fail_cnt = 0;
  int           total_cnt = 0;
  int           n;

  always #5 clock = ~clock;

  icache_2way_param dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .flush        (flush),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // Memory: word k of block a is (a << 8) + 10 + k, so block 0 is 0xD_C_B_A.
  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = {18'd0, a, 8'h00} + 32'(10 + k);
    return b;
  endfunction

  // Three busy cycles per read, then one ready cycle
  always @(posedge clock) begin
    if (mem_read && busy_cnt_r != 2'd3) busy_cnt_r <= busy_cnt_r + 2'd1;
    else                                busy_cnt_r <= 2'd0;
  end

  assign mem_busywait = !(mem_read && busy_cnt_r == 2'd3);
  assign mem_readdata = blk(mem_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (busywait === 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp);
    pc = a;
    #1;
    check($sformatf("hit_%h_busywait", a), {31'd0, busywait}, 32'd0);
    check($sformatf("hit_%h_instr", a), instruction, exp);
    check($sformatf("hit_%h_mem_read", a), {31'd0, mem_read}, 32'd0);
    tick();
  endtask

  task automatic fetch_miss(input logic [31:0] a, input logic [5:0] addr, input logic [31:0] exp);
    int c;
    pc = a;
    #1;
    check($sformatf("miss_%h_busywait", a), {31'd0, busywait}, 32'd1);
    check($sformatf("miss_%h_instr", a), instruction, 32'd0);
    tick();
    check($sformatf("miss_%h_mem_read", a), {31'd0, mem_read}, 32'd1);
    check($sformatf("miss_%h_mem_address", a), {26'd0, mem_address}, {26'd0, addr});
    wait_ready(c);
    check($sformatf("miss_%h_memread_cycles", a), c, 32'd4);
    check($sformatf("miss_%h_refill_instr", a), instruction, exp);
    check($sformatf("miss_%h_mem_read_done", a), {31'd0, mem_read}, 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    pc    = 32'h0000_0000;
    #1;
    check("reset_busywait", {31'd0, busywait}, 32'd0);
    check("reset_mem_read", {31'd0, mem_read}, 32'd0);
    check("reset_mem_address", {26'd0, mem_address}, 32'd0);
    check("reset_instr", instruction, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Cold miss on block 0: busywait high 1 + 4 cycles
    fetch_miss(32'h000, 6'h00, 32'h0000_000A);

    // Remaining words of block 0
    fetch_hit(32'h004, 32'h0000_000B);
    fetch_hit(32'h008, 32'h0000_000C);
    fetch_hit(32'h00C, 32'h0000_000D);

    // LRU: 0x040 fills way 1, 0x000 touched, 0x080 evicts way 1
    fetch_miss(32'h040, 6'h04, 32'h0000_040A);
    fetch_hit(32'h000, 32'h0000_000A);
    fetch_miss(32'h080, 6'h08, 32'h0000_080A);
    fetch_hit(32'h000, 32'h0000_000A);
    fetch_miss(32'h040, 6'h04, 32'h0000_040A);

    // Flush on a hit still returns the word, then everything misses
    pc    = 32'h000;
    flush = 1'b1;
    #1;
    check("flush_hit_instr", instruction, 32'h0000_000A);
    check("flush_hit_busywait", {31'd0, busywait}, 32'd0);
    tick();
    flush = 1'b0;
    fetch_miss(32'h000, 6'h00, 32'h0000_000A);

    // Flush on the refill-completion edge discards the block
    pc = 32'h0C0;
    #1;
    check("flushfill_busywait", {31'd0, busywait}, 32'd1);
    n = 0;
    while (!(mem_read === 1'b1 && mem_busywait === 1'b0) && n < 20) begin
      tick();
      n++;
    end
    check("flushfill_reach_ready", n, 32'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushfill_idle_mem_read", {31'd0, mem_read}, 32'd0);
    check("flushfill_idle_busywait", {31'd0, busywait}, 32'd1);
    tick();
    check("flushfill_reread", {31'd0, mem_read}, 32'd1);
    check("flushfill_reread_addr", {26'd0, mem_address}, 32'h0C);
    wait_ready(n);
    check("flushfill_reread_cycles", n, 32'd4);
    check("flushfill_instr", instruction, 32'h0000_0C0A);
    tick();

    // Async reset in the second MEM_READ cycle
    pc = 32'h100;
    #1;
    check("rstmid_busywait", {31'd0, busywait}, 32'd1);
    tick();
    check("rstmid_mem_read_1", {31'd0, mem_read}, 32'd1);
    tick();
    check("rstmid_mem_read_2", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_mem_read", {31'd0, mem_read}, 32'd0);
    check("rstmid_busywait_low", {31'd0, busywait}, 32'd0);
    check("rstmid_mem_address", {26'd0, mem_address}, 32'd0);
    check("rstmid_instr", instruction, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    fetch_miss(32'h0C0, 6'h0C, 32'h0000_0C0A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
